// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   HALF_W / FULL_W : memory word width (24) and wide access width (48),
//                     taken from the DMEM_HALF_W / DMEM_FULL_W size macros.
//   arb_state_e     : arbiter state (ARB_PIPE, ARB_FORCE).
//   owner_e         : owner tag of an outstanding read (OWN_P, OWN_X).
`ifndef DMEM_HALF_W
`define DMEM_HALF_W 24
`endif
`ifndef DMEM_FULL_W
`define DMEM_FULL_W 48
`endif

package dmem_arb_pkg;
  localparam int HALF_W = `DMEM_HALF_W;
  localparam int FULL_W = `DMEM_FULL_W;

  typedef enum logic {
    ARB_PIPE  = 1'b0,
    ARB_FORCE = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_P = 1'b0,
    OWN_X = 1'b1
  } owner_e;
endpackage

// File: rtl/dmem_arb_split.sv
// dmem_arb_split: maps one granted request onto the two memory ports.
//   en_i                 : a request is granted this cycle (else both ports idle)
//   we_i, wide_i         : write / 48-bit access flags of the granted request
//   addr_i, wdata_i      : word address and write data of the granted request
//   we0_o/we1_o, addr0_o/addr1_o, wdata0_o/wdata1_o : memory port controls
// Wide accesses put the upper half on port0 at A and the lower half on port1
// at A+1; the address increment wraps modulo 2^FULL_W.
module dmem_arb_split
  import dmem_arb_pkg::*;
(
  input  logic              en_i,
  input  logic              we_i,
  input  logic              wide_i,
  input  logic [FULL_W-1:0] addr_i,
  input  logic [FULL_W-1:0] wdata_i,
  output logic              we0_o,
  output logic              we1_o,
  output logic [FULL_W-1:0] addr0_o,
  output logic [FULL_W-1:0] addr1_o,
  output logic [HALF_W-1:0] wdata0_o,
  output logic [HALF_W-1:0] wdata1_o
);

  always_comb begin
    we0_o    = 1'b0;
    we1_o    = 1'b0;
    addr0_o  = '0;
    addr1_o  = '0;
    wdata0_o = '0;
    wdata1_o = '0;
    if (en_i) begin
      we0_o   = we_i;
      addr0_o = addr_i;
      if (wide_i) begin
        wdata0_o = wdata_i[FULL_W-1:HALF_W];
        we1_o    = we_i;
        addr1_o  = addr_i + FULL_W'(1);
        wdata1_o = wdata_i[HALF_W-1:0];
      end else begin
        wdata0_o = wdata_i[HALF_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// dmem_arb: arbitrates the dual-port 24-bit data memory between the pipeline
// (requester P) and an auxiliary master (requester X).
//   iw_clk, iw_rst           : clock, synchronous active-high reset
//   iw_p_* / iw_x_*          : request valid, we, wide, addr, wdata
//   ow_p_stall               : P not taken this cycle (P holds its request)
//   ow_x_ready               : X accepted this cycle
//   ow_p_rvalid/ow_p_rdata   : P read response, one cycle after grant
//   ow_x_rvalid/ow_x_rdata   : X read response, one cycle after grant
//   ow_mem_* / iw_mem_rdata* : dual-port memory interface
// Optional: define DMEM_ARB_PERF_EN to add ow_perf_p_grants, ow_perf_x_grants,
// ow_perf_p_stalls and ow_perf_x_waits counters (PERF_W bits, wrapping).
//
// Handshake: P is granted in any cycle where iw_p_valid=1 and ow_p_stall=0;
// X is granted in any cycle where iw_x_valid=1 and ow_x_ready=1. Both
// requesters keep their request stable until granted. A granted read returns
// exactly one rvalid pulse on the owner's side in the following cycle.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_W     = 4
`ifdef DMEM_ARB_PERF_EN
  ,
  parameter int PERF_W       = 32
`endif
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_p_valid,
  input  logic              iw_p_we,
  input  logic              iw_p_wide,
  input  logic [FULL_W-1:0] iw_p_addr,
  input  logic [FULL_W-1:0] iw_p_wdata,
  output logic              ow_p_stall,
  output logic              ow_p_rvalid,
  output logic [FULL_W-1:0] ow_p_rdata,
  input  logic              iw_x_valid,
  input  logic              iw_x_we,
  input  logic              iw_x_wide,
  input  logic [FULL_W-1:0] iw_x_addr,
  input  logic [FULL_W-1:0] iw_x_wdata,
  output logic              ow_x_ready,
  output logic              ow_x_rvalid,
  output logic [FULL_W-1:0] ow_x_rdata,
  output logic              ow_mem_we0,
  output logic              ow_mem_we1,
  output logic [FULL_W-1:0] ow_mem_addr0,
  output logic [FULL_W-1:0] ow_mem_addr1,
  output logic [HALF_W-1:0] ow_mem_wdata0,
  output logic [HALF_W-1:0] ow_mem_wdata1,
  input  logic [HALF_W-1:0] iw_mem_rdata0,
  input  logic [HALF_W-1:0] iw_mem_rdata1
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] ow_perf_p_grants,
  output logic [PERF_W-1:0] ow_perf_x_grants,
  output logic [PERF_W-1:0] ow_perf_p_stalls,
  output logic [PERF_W-1:0] ow_perf_x_waits
`endif
);

  localparam logic [STARVE_W-1:0] CNT_MAX = {STARVE_W{1'b1}};

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] cnt_q, cnt_d;
  logic                p_grant, x_grant, p_stall;
  logic                rvalid_q, rvalid_d;
  logic                wide_q, wide_d;
  owner_e              owner_q, owner_d;

  logic                sel_en, sel_we, sel_wide;
  logic [FULL_W-1:0]   sel_addr, sel_wdata;
  logic [FULL_W-1:0]   rd_full;

  // Grant and next-state logic. Reset suppresses every grant so the memory
  // sees idle ports and no read gets captured.
  always_comb begin
    p_grant = 1'b0;
    x_grant = 1'b0;
    p_stall = 1'b0;
    state_d = ARB_PIPE;
    cnt_d   = '0;
    if (!iw_rst) begin
      if (state_q == ARB_FORCE && iw_x_valid) begin
        x_grant = 1'b1;
        p_stall = iw_p_valid;
      end else if (iw_p_valid) begin
        p_grant = 1'b1;
      end else if (iw_x_valid) begin
        x_grant = 1'b1;
      end
      // Only a denied X counts; a grant or an idle X clears the count.
      // ARB_FORCE always falls back to ARB_PIPE with the count cleared.
      if (iw_x_valid && !x_grant) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (STARVE_LIMIT != 0 && cnt_d == STARVE_W'(STARVE_LIMIT)) begin
          state_d = ARB_FORCE;
        end
      end
    end
  end

  assign sel_en    = p_grant | x_grant;
  assign sel_we    = x_grant ? iw_x_we    : iw_p_we;
  assign sel_wide  = x_grant ? iw_x_wide  : iw_p_wide;
  assign sel_addr  = x_grant ? iw_x_addr  : iw_p_addr;
  assign sel_wdata = x_grant ? iw_x_wdata : iw_p_wdata;

  assign rvalid_d = sel_en & ~sel_we;
  assign owner_d  = x_grant ? OWN_X : OWN_P;
  assign wide_d   = sel_wide;

  dmem_arb_split u_split (
    .en_i     (sel_en),
    .we_i     (sel_we),
    .wide_i   (sel_wide),
    .addr_i   (sel_addr),
    .wdata_i  (sel_wdata),
    .we0_o    (ow_mem_we0),
    .we1_o    (ow_mem_we1),
    .addr0_o  (ow_mem_addr0),
    .addr1_o  (ow_mem_addr1),
    .wdata0_o (ow_mem_wdata0),
    .wdata1_o (ow_mem_wdata1)
  );

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q  <= ARB_PIPE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      wide_q   <= 1'b0;
      owner_q  <= OWN_P;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      wide_q   <= wide_d;
      owner_q  <= owner_d;
    end
  end

  assign ow_p_stall = p_stall;
  assign ow_x_ready = x_grant;

  // Response gating on iw_rst drops a read whose response cycle coincides
  // with reset.
  assign rd_full     = wide_q ? {iw_mem_rdata0, iw_mem_rdata1}
                              : {{HALF_W{1'b0}}, iw_mem_rdata0};
  assign ow_p_rvalid = rvalid_q & (owner_q == OWN_P) & ~iw_rst;
  assign ow_x_rvalid = rvalid_q & (owner_q == OWN_X) & ~iw_rst;
  assign ow_p_rdata  = ow_p_rvalid ? rd_full : '0;
  assign ow_x_rdata  = ow_x_rvalid ? rd_full : '0;

`ifdef DMEM_ARB_PERF_EN
  logic [PERF_W-1:0] perf_pg_q, perf_xg_q, perf_ps_q, perf_xw_q;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      perf_pg_q <= '0;
      perf_xg_q <= '0;
      perf_ps_q <= '0;
      perf_xw_q <= '0;
    end else begin
      perf_pg_q <= perf_pg_q + PERF_W'(p_grant);
      perf_xg_q <= perf_xg_q + PERF_W'(x_grant);
      perf_ps_q <= perf_ps_q + PERF_W'(p_stall);
      perf_xw_q <= perf_xw_q + PERF_W'(iw_x_valid & ~x_grant);
    end
  end

  assign ow_perf_p_grants = perf_pg_q;
  assign ow_perf_x_grants = perf_xg_q;
  assign ow_perf_p_stalls = perf_ps_q;
  assign ow_perf_x_waits  = perf_xw_q;
`endif

endmodule
